// File: rtl/bootdata_sender.sv
// bootdata_sender: frames a ROM image byte stream into big-endian 32-bit
// words and delivers each one to the cartridge loader with a four-phase
// req/ack handshake, after pulsing the loader reset.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   start, rom_size     - begin a transfer of rom_size bytes (idle only)
//   byte_data/valid     - incoming image byte stream
//   byte_ready          - a byte is accepted this cycle
//   host_bootdata       - packed word, first byte in [31:24]
//   host_bootdata_req   - word valid request to the loader
//   host_bootdata_ack   - loader acknowledge
//   host_bootdata_reset - loader reset pulse
//   host_bootdata_size  - image size latched at start
//   busy, done, error   - transfer status
module bootdata_sender #(
    parameter logic [7:0]  RESET_CYCLES = 8'd4,
    parameter logic [7:0]  PAD_BYTE     = 8'hFF,
    parameter logic [15:0] ACK_TIMEOUT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rom_size,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic        host_bootdata_reset,
    output logic [15:0] host_bootdata_size,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LRST,
        FILL,
        REQ,
        WAITLO,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] remaining;
    logic [1:0]  idx;
    logic [7:0]  rst_cnt;
    logic [15:0] to_cnt;
    logic [31:0] word_nx;

    logic        accept;
    logic        take;
    logic        last_byte;
    logic        timeout;
    logic        in_hs;

    assign byte_ready = (state == FILL);
    assign busy       = (state == LRST) || (state == FILL) ||
                        (state == REQ)  || (state == WAITLO);

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign take      = byte_valid && byte_ready;
    // A word closes on its fourth lane or on the final image byte.
    assign last_byte = (idx == 2'd3) || (remaining == 16'd1);
    assign timeout   = (to_cnt == ACK_TIMEOUT);
    assign in_hs     = (state == REQ) || (state == WAITLO);

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = LRST;
                end
            end
            LRST: begin
                if (rst_cnt == 8'd0) begin
                    state_nx = (remaining == 16'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (take && last_byte) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (host_bootdata_ack) begin
                    state_nx = WAITLO;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WAITLO: begin
                if (!host_bootdata_ack) begin
                    state_nx = (remaining == 16'd0) ? DONE : FILL;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Lane merge: the incoming byte lands in lane idx; when it closes
    // the word, every lane after it is padded.
    always_comb begin
        word_nx = host_bootdata;
        for (int l = 0; l < 4; l++) begin
            if (int'(idx) == l) begin
                word_nx[31-8*l -: 8] = byte_data;
            end else if (last_byte && (l > int'(idx))) begin
                word_nx[31-8*l -: 8] = PAD_BYTE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            host_bootdata       <= 32'hFFFF_FFFF;
            host_bootdata_req   <= 1'b0;
            host_bootdata_reset <= 1'b0;
            host_bootdata_size  <= 16'd0;
            done                <= 1'b0;
            error               <= 1'b0;
            remaining           <= 16'd0;
            idx                 <= 2'd0;
            rst_cnt             <= 8'd0;
            to_cnt              <= 16'd0;
        end else begin
            // Both are looked ahead from state_nx so they are registered
            // yet line up with the state they belong to.
            host_bootdata_reset <= (state_nx == LRST);
            host_bootdata_req   <= (state_nx == REQ);

            if (accept) begin
                host_bootdata_size <= rom_size;
                remaining          <= rom_size;
                rst_cnt            <= RESET_CYCLES - 8'd1;
                done               <= 1'b0;
                error              <= 1'b0;
            end

            if ((state == LRST) && (rst_cnt != 8'd0)) begin
                rst_cnt <= rst_cnt - 8'd1;
            end

            if ((state_nx == FILL) && (state != FILL)) begin
                idx <= 2'd0;
            end else if (take) begin
                idx <= idx + 2'd1;
            end

            if (take) begin
                host_bootdata <= word_nx;
                remaining     <= remaining - 16'd1;
            end

            // Each ack edge gets its own timeout window.
            if (state_nx != state) begin
                to_cnt <= 16'd0;
            end else if (in_hs) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if ((state_nx == DONE) && (state != DONE)) begin
                done <= 1'b1;
            end

            if (in_hs && (state_nx == IDLE)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bootdata_sender.sv
// tb_bootdata_sender: randomized self-checking bench for bootdata_sender
// with a loader ack responder and a byte-level reference model.
module tb_bootdata_sender;

    localparam int RC = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rom_size = 16'd0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack = 1'b0;
    logic        host_bootdata_reset;
    logic [15:0] host_bootdata_size;
    logic        busy;
    logic        done;
    logic        error;

    bootdata_sender #(
        .RESET_CYCLES(8'(RC)),
        .PAD_BYTE    (8'hFF),
        .ACK_TIMEOUT (16'(TO))
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .rom_size           (rom_size),
        .byte_data          (byte_data),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .host_bootdata      (host_bootdata),
        .host_bootdata_req  (host_bootdata_req),
        .host_bootdata_ack  (host_bootdata_ack),
        .host_bootdata_reset(host_bootdata_reset),
        .host_bootdata_size (host_bootdata_size),
        .busy               (busy),
        .done               (done),
        .error              (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  src[$];
    logic [7:0]  expb[$];
    logic [31:0] got[$];
    int          req_rises = 0;
    time         t_rise = 0;
    bit          ack_on = 1'b1;
    int          ack_max = 0;
    int          ad = 0;
    int          aw = 0;
    bit          rq_q = 1'b0;

    int          cur_size;
    int          accepted;
    int          vmode;
    int          vpct;
    bit          tog;
    int          g0;
    int          r0;
    int          stab_err;
    logic        ho_br;
    logic        ho_req;

    // Loader model: raises ack ad cycles after seeing req, drops it ad
    // cycles after req falls, and records the word it acknowledged.
    always @(negedge clk) begin
        if (host_bootdata_req && !rq_q) begin
            req_rises++;
            t_rise = $time;
        end
        rq_q = host_bootdata_req;
        if (reset || !ack_on) begin
            host_bootdata_ack = 1'b0;
            aw = 0;
        end else if (!host_bootdata_ack) begin
            if (host_bootdata_req) begin
                if (aw >= ad) begin
                    host_bootdata_ack = 1'b1;
                    got.push_back(host_bootdata);
                    aw = 0;
                end else begin
                    aw++;
                end
            end
        end else if (!host_bootdata_req) begin
            if (aw >= ad) begin
                host_bootdata_ack = 1'b0;
                aw = 0;
                ad = int'($urandom_range(0, ack_max));
            end else begin
                aw++;
            end
        end
    end

    // Reference model: word w of an n-byte image, big-endian, FF padded.
    function automatic logic [31:0] exp_word(input logic [7:0] b[$],
                                             input int n, input int w);
        logic [31:0] r;
        logic [7:0]  v;
        r = 32'd0;
        for (int k = 0; k < 4; k++) begin
            v = (4*w + k < n) ? b[4*w + k] : 8'hFF;
            r = (r << 8) | 32'(v);
        end
        return r;
    endfunction

    task automatic prep(input int size, input bit rnd,
                        input logic [7:0] first, input logic [7:0] step);
        logic [7:0] v;
        src.delete();
        expb.delete();
        v = first;
        for (int i = 0; i < size; i++) begin
            if (rnd) v = 8'($urandom);
            src.push_back(v);
            expb.push_back(v);
            v = v + step;
        end
        for (int i = 0; i < 3; i++) src.push_back(8'($urandom));
        cur_size = size;
        accepted = 0;
        stab_err = 0;
        ho_br    = 1'b1;
        ho_req   = 1'b0;
        g0       = got.size();
        r0       = req_rises;
    endtask

    task automatic kick(input int size);
        @(negedge clk);
        start    = 1'b1;
        rom_size = 16'(size);
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic feed(input int lim, input bit stop_req, output bit ok);
        bit          pend;
        bit          live;
        bit          prq;
        bit          v;
        logic [31:0] lw;
        pend = 1'b0;
        live = 1'b0;
        prq  = 1'b0;
        ok   = 1'b0;
        lw   = 32'd0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (pend) begin
                ho_br  = byte_ready;
                ho_req = host_bootdata_req;
                pend   = 1'b0;
            end
            if (host_bootdata_req && !prq) begin
                lw   = host_bootdata;
                live = 1'b1;
            end else if (live && (host_bootdata_req || host_bootdata_ack)
                         && (host_bootdata !== lw)) begin
                stab_err++;
            end
            prq = host_bootdata_req;
            if (done || error || (stop_req && host_bootdata_req)) begin
                ok = 1'b1;
                byte_valid = 1'b0;
                return;
            end
            if (vmode == 1) begin
                tog = !tog;
                v   = tog;
            end else begin
                v = (int'($urandom_range(0, 99)) < vpct);
            end
            v = v && (src.size() > 0);
            byte_valid = v;
            byte_data  = v ? src[0] : 8'($urandom);
            if (v && byte_ready) begin
                void'(src.pop_front());
                accepted++;
                if (accepted == cur_size) pend = 1'b1;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({host_bootdata_req, host_bootdata_reset, byte_ready,
             busy, done, error} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {host_bootdata_req, host_bootdata_reset,
                      byte_ready, busy, done, error});
        end
        n_cmp++;
        if (host_bootdata !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL reset_word: got %h required ffffffff",
                     host_bootdata);
        end
        n_cmp++;
        if (host_bootdata_size !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_size: got %0d required 0",
                     host_bootdata_size);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        bit ok;
        ack_max = 0;
        vmode   = 0;
        vpct    = 100;
        prep(8, 1'b0, 8'h01, 8'h01);
        kick(8);
        feed(2000, 1'b0, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: ok=%0d done=%b error=%b required 1/1/0",
                     ok, done, error);
        end
        n_cmp++;
        if (got.size() - g0 != 2 || req_rises - r0 != 2) begin
            n_bad++;
            $display("FAIL basic_count: words=%0d reqs=%0d required 2/2",
                     got.size() - g0, req_rises - r0);
        end
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (got.size() <= g0 + w ||
                got[g0 + w] !== exp_word(expb, 8, w)) begin
                n_bad++;
                $display("FAIL basic_word%0d: got %h required %h", w,
                         (got.size() > g0 + w) ? got[g0 + w] : 32'hx,
                         exp_word(expb, 8, w));
            end
        end
        n_cmp++;
        if (host_bootdata_size !== 16'd8 || src.size() != 3) begin
            n_bad++;
            $display("FAIL basic_size: size=%0d left=%0d required 8/3",
                     host_bootdata_size, src.size());
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_bad++;
            $display("FAIL basic_stable: changes=%0d required 0", stab_err);
        end
    endtask

    task automatic test_pad;
        bit ok;
        prep(6, 1'b0, 8'hA1, 8'h01);
        kick(6);
        feed(2000, 1'b0, ok);
        n_cmp++;
        if (!ok || got.size() - g0 != 2) begin
            n_bad++;
            $display("FAIL pad_count: ok=%0d words=%0d required 1/2",
                     ok, got.size() - g0);
        end
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (got.size() <= g0 + w ||
                got[g0 + w] !== exp_word(expb, 6, w)) begin
                n_bad++;
                $display("FAIL pad_word%0d: got %h required %h", w,
                         (got.size() > g0 + w) ? got[g0 + w] : 32'hx,
                         exp_word(expb, 6, w));
            end
        end
        n_cmp++;
        if (ho_br !== 1'b0 || ho_req !== 1'b1) begin
            n_bad++;
            $display("FAIL pad_handoff: byte_ready=%b req=%b required 0/1",
                     ho_br, ho_req);
        end
    endtask

    task automatic test_toggle;
        bit ok;
        vmode = 1;
        tog   = 1'b0;
        prep(4, 1'b0, 8'h11, 8'h11);
        kick(4);
        feed(2000, 1'b0, ok);
        vmode = 0;
        n_cmp++;
        if (!ok || got.size() - g0 != 1 || accepted != 4 ||
            src.size() != 3) begin
            n_bad++;
            $display("FAIL toggle_count: words=%0d taken=%0d left=%0d required 1/4/3",
                     got.size() - g0, accepted, src.size());
        end
        n_cmp++;
        if (got.size() <= g0 || got[g0] !== exp_word(expb, 4, 0)) begin
            n_bad++;
            $display("FAIL toggle_word: got %h required %h",
                     (got.size() > g0) ? got[g0] : 32'hx,
                     exp_word(expb, 4, 0));
        end
    endtask

    task automatic test_start_held;
        bit ok;
        int hi;
        int first_br;
        prep(4, 1'b1, 8'h00, 8'h00);
        hi = 0;
        first_br = -1;
        @(negedge clk);
        start    = 1'b1;
        rom_size = 16'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (host_bootdata_reset) hi++;
            if (byte_ready && first_br < 0) first_br = i + 1;
        end
        start = 1'b0;
        n_cmp++;
        if (hi != RC) begin
            n_bad++;
            $display("FAIL held_reset_len: got %0d cycles required %0d",
                     hi, RC);
        end
        n_cmp++;
        if (first_br != RC + 1) begin
            n_bad++;
            $display("FAIL held_fill_entry: cycle %0d required %0d",
                     first_br, RC + 1);
        end
        kick(99);
        n_cmp++;
        if (host_bootdata_size !== 16'd4 || host_bootdata_reset !== 1'b0 ||
            byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start: size=%0d rst=%b ready=%b required 4/0/1",
                     host_bootdata_size, host_bootdata_reset, byte_ready);
        end
        feed(2000, 1'b0, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || got.size() <= g0 ||
            got[g0] !== exp_word(expb, 4, 0)) begin
            n_bad++;
            $display("FAIL held_word: done=%b got %h required 1/%h", done,
                     (got.size() > g0) ? got[g0] : 32'hx,
                     exp_word(expb, 4, 0));
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int el;
        ack_on = 1'b0;
        prep(4, 1'b1, 8'h00, 8'h00);
        kick(4);
        feed(2000, 1'b0, ok);
        el = int'(($time - t_rise) / 10);
        n_cmp++;
        if (!ok || error !== 1'b1 || el < 1 || el > TO + 1) begin
            n_bad++;
            $display("FAIL timeout_err: error=%b after %0d cycles required 1 within %0d",
                     error, el, TO + 1);
        end
        n_cmp++;
        if (host_bootdata_req !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || got.size() != g0) begin
            n_bad++;
            $display("FAIL timeout_idle: req=%b busy=%b done=%b words=%0d required 0/0/0/0",
                     host_bootdata_req, busy, done, got.size() - g0);
        end
        ack_on = 1'b1;
        prep(0, 1'b1, 8'h00, 8'h00);
        kick(0);
        n_cmp++;
        if (error !== 1'b0 || host_bootdata_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_clear: error=%b rst=%b required 0/1",
                     error, host_bootdata_reset);
        end
        feed(200, 1'b0, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || req_rises != r0 || src.size() != 3) begin
            n_bad++;
            $display("FAIL zero_size: done=%b reqs=%0d left=%0d required 1/0/3",
                     done, req_rises - r0, src.size());
        end
    endtask

    task automatic test_reset_in_req;
        bit ok;
        ack_on = 1'b0;
        prep(4, 1'b1, 8'h00, 8'h00);
        kick(4);
        feed(2000, 1'b1, ok);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (!ok || host_bootdata_req !== 1'b0 || busy !== 1'b0 ||
            host_bootdata_size !== 16'd0 || host_bootdata !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL mid_reset: req=%b busy=%b size=%0d word=%h required 0/0/0/ffffffff",
                     host_bootdata_req, busy, host_bootdata_size,
                     host_bootdata);
        end
        reset  = 1'b0;
        ack_on = 1'b1;
        prep(4, 1'b1, 8'h00, 8'h00);
        kick(4);
        feed(2000, 1'b0, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || got.size() - g0 != 1 ||
            got[g0] !== exp_word(expb, 4, 0)) begin
            n_bad++;
            $display("FAIL after_reset: done=%b words=%0d got %h required 1/1/%h",
                     done, got.size() - g0,
                     (got.size() > g0) ? got[g0] : 32'hx,
                     exp_word(expb, 4, 0));
        end
    endtask

    task automatic test_random;
        bit ok;
        int n;
        int nw;
        for (int it = 0; it < 6; it++) begin
            n       = int'($urandom_range(1, 23));
            ack_max = int'($urandom_range(0, 6));
            vpct    = int'($urandom_range(30, 100));
            vmode   = 0;
            prep(n, 1'b1, 8'h00, 8'h00);
            nw = (n + 3) / 4;
            kick(n);
            feed(3000, 1'b0, ok);
            n_cmp++;
            if (!ok || done !== 1'b1 || error !== 1'b0 ||
                got.size() - g0 != nw || req_rises - r0 != nw ||
                src.size() != 3) begin
                n_bad++;
                $display("FAIL rand%0d_count: n=%0d words=%0d reqs=%0d left=%0d required %0d/%0d/3",
                         it, n, got.size() - g0, req_rises - r0,
                         src.size(), nw, nw);
            end
            for (int w = 0; w < nw; w++) begin
                n_cmp++;
                if (got.size() <= g0 + w ||
                    got[g0 + w] !== exp_word(expb, n, w)) begin
                    n_bad++;
                    $display("FAIL rand%0d_word%0d: got %h required %h",
                             it, w,
                             (got.size() > g0 + w) ? got[g0 + w] : 32'hx,
                             exp_word(expb, n, w));
                end
            end
            n_cmp++;
            if (ho_br !== 1'b0 || ho_req !== 1'b1 || stab_err != 0 ||
                host_bootdata_size !== 16'(n)) begin
                n_bad++;
                $display("FAIL rand%0d_misc: ready=%b req=%b changes=%0d size=%0d required 0/1/0/%0d",
                         it, ho_br, ho_req, stab_err,
                         host_bootdata_size, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_toggle();
        test_start_held();
        test_timeout();
        test_reset_in_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bootdata_sender.md
# bootdata_sender

Host-side transmitter for the boot-data word protocol used by the cartridge ROM loader. Accepts a ROM image as a byte stream, from the SD or control-module reader, and frames the transfer. It drives the loader reset, publishes the image size, packs bytes big-endian into 32-bit words and delivers each word with a four-phase req/ack handshake. It sits between the host byte source and the loader's `host_bootdata*` inputs, in the same clock domain.

## Interface
- `RESET_CYCLES`, default 4: number of cycles `host_bootdata_reset` is held high at transfer start (1..255).
- `PAD_BYTE`, default 8'hFF: fill value for unused byte lanes of the final word.
- `ACK_TIMEOUT`, default 16'hFFFF: maximum cycles spent waiting on any single ack edge before aborting.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a transfer; ignored unless idle.
- `rom_size` in 16: image length in bytes; sampled on accepted `start`.
- `byte_data` in 8: image byte.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_ready` out 1: block accepts a byte this cycle.
- `host_bootdata` out 32: packed word; first byte of each group in [31:24].
- `host_bootdata_req` out 1: word valid request.
- `host_bootdata_ack` in 1: loader acknowledge.
- `host_bootdata_reset` out 1: loader reset pulse.
- `host_bootdata_size` out 16: latched `rom_size`.
- `busy` out 1: transfer in progress.
- `done` out 1: last transfer completed; held until next accepted `start`.
- `error` out 1: last transfer aborted on timeout; held until next accepted `start`.

## Operation
- States: IDLE, LRST, FILL, REQ, WAITLO, DONE.
- IDLE:
  - `start`=1: latch `rom_size` into `host_bootdata_size` and into `remaining`, clear `done`/`error`, load the reset counter, go to LRST.
- LRST:
  - `host_bootdata_reset`=1 for exactly RESET_CYCLES cycles.
  - Then: go to DONE if `remaining`==0, otherwise go to FILL with lane index 0.
- FILL:
  - `byte_ready`=1.
  - On `byte_valid`&`byte_ready`: write the byte to lane `idx` (idx 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]), then `remaining`-=1 and `idx`+=1.
  - On accepting the byte at idx=3, or the byte that makes `remaining` 0: fill every higher lane with PAD_BYTE, go to REQ.
- REQ:
  - `host_bootdata_req`=1; `host_bootdata` stays stable.
  - On `host_bootdata_ack`=1: go to WAITLO.
- WAITLO:
  - `host_bootdata_req`=0.
  - On `host_bootdata_ack`=0: go to DONE if `remaining`==0, otherwise go to FILL with idx=0.
- DONE: `done`=1; behaves as IDLE for `start`.
- Timeout:
  - A 16-bit counter clears on entry to REQ and on entry to WAITLO.
  - When it reaches ACK_TIMEOUT in either state: `error`=1, `req`=0, go to IDLE.
- Word count is ceil(`rom_size`/4). Bytes beyond `rom_size` are never requested.
- `start` while `busy` is ignored, with no effect on any register.
- `busy`=1 in LRST, FILL, REQ and WAITLO.

## Timing
- Reset values:
  - state IDLE.
  - `host_bootdata_req`, `host_bootdata_reset`, `byte_ready`, `busy`, `done`, `error` = 0.
  - `host_bootdata` = 32'hFFFFFFFF.
  - `host_bootdata_size` = 0.
- All outputs are registered except `byte_ready` and `busy`, which are decoded from state.
- Transfer start:
  - `start` sampled high at cycle 0: `host_bootdata_reset` is high in cycles 1..RESET_CYCLES.
  - `host_bootdata_size` is valid from cycle 1 and stays valid throughout the reset pulse.
  - FILL is entered at cycle RESET_CYCLES+1.
- FILL accepts at most one byte per cycle.
- `req` rises in the cycle after the completing byte is accepted.
- `host_bootdata` stays constant from the cycle `req` rises until WAITLO exits.
- Handshake:
  - ack sampled high -> `req` low in the next cycle.
  - ack sampled low in WAITLO -> `byte_ready` high in the next cycle.
  - The loader ignores `req` while it writes a word's four bytes, so a `req` that is already high again may wait several cycles for ack. This is legal.
- Synchronous `reset` mid-transfer: all outputs return to reset values in the next cycle, including `req` and `host_bootdata_reset` dropping. Partial data is discarded.
- `rom_size`=0: LRST then DONE; no `req` is ever raised.

## Test plan
- `rom_size`=8, bytes 01..08, ack model raises ack 1 cycle after req and drops it 1 cycle after req falls -> words 01020304 then 05060708, exactly 2 req pulses, `done`=1, `host_bootdata_size`=8.
- `rom_size`=6, bytes A1..A6 -> words A1A2A3A4 then A5A6FFFF; `byte_ready` low after the 6th byte.
- `byte_valid` toggling every other cycle with `rom_size`=4 -> single word 11223344, correct lane order, no duplicated or lost bytes.
- `start` held high, RESET_CYCLES=4 -> reset high exactly 4 cycles; a second `start` while busy does not restart the transfer.
- Ack never asserted, ACK_TIMEOUT=16 -> `error`=1 and `req`=0 within 17 cycles of `req` rising; state IDLE; a new `start` clears `error`.
- `reset` asserted while in REQ -> next cycle `req`=0, `busy`=0, `host_bootdata_size`=0; a subsequent transfer with `rom_size`=4 completes normally.
